// File: rtl/moore_111010_ov.sv
// ---------------------------------------------------------------------------
// moore_111010_ov
//
// Serial pattern detector for the bit sequence 1,1,1,0,1,0 (first bit
// received first). It is a Moore FSM with overlapping detection, so the tail
// of one match can start the next one. Each state records the longest prefix
// of the pattern that has been matched so far.
//
// Ports:
//   in_seq  - serial data bit, sampled on each rising edge of clk
//   clk     - rising-edge clock
//   rst     - asynchronous, active-high reset; forces S0 and det_out = 0
//   det_out - high for exactly one clock while the FSM is in the detect state
// ---------------------------------------------------------------------------
module moore_111010_ov (
    input  logic in_seq,
    input  logic clk,
    input  logic rst,
    output logic det_out
);

    typedef enum logic [2:0] {
        S0 = 3'd0,  // nothing matched
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "11"
        S3 = 3'd3,  // "111"
        S4 = 3'd4,  // "1110"
        S5 = 3'd5,  // "11101"
        S6 = 3'd6   // "111010" (detect state)
    } state_t;

    state_t state;
    state_t state_nxt;

    // Next-state rule. On a mismatch, the FSM falls back to the longest
    // pattern prefix that is still a suffix of the bits seen so far. Encoding
    // 3'b111 is unused and falls back to S0.
    function automatic state_t next_state(input state_t s, input logic b);
        state_t n;
        n = S0;
        case (s)
            S0:      n = b ? S1 : S0;
            S1:      n = b ? S2 : S0;
            S2:      n = b ? S3 : S0;
            S3:      n = b ? S3 : S4;  // a longer run of 1s still ends in "111"
            S4:      n = b ? S5 : S0;
            S5:      n = b ? S2 : S6;  // "111011" still ends in "11"
            S6:      n = b ? S1 : S0;  // the trailing "1" starts a new match
            default: n = S0;
        endcase
        return n;
    endfunction

    always_comb begin
        state_nxt = next_state(state, in_seq);
    end

    // det_out is registered from the next-state decode. It therefore rises
    // and falls together with entry into and exit from S6. It has no
    // combinational path from in_seq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S0;
            det_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            det_out <= (state_nxt == S6);
        end
    end

endmodule

// File: tb/tb_moore_111010_ov.sv
// ---------------------------------------------------------------------------
// tb_moore_111010_ov
//
// Self-checking bench for moore_111010_ov.
//
// The directed scenarios state the cycle at which each detection pulse is
// expected. The randomized scenario compares the DUT against a reference
// model. That model keeps a 6-bit window of the bits received since the last
// reset, and it predicts a detection whenever the window holds 111010.
// ---------------------------------------------------------------------------
module tb_moore_111010_ov;

    logic in_seq;
    logic clk;
    logic rst;
    logic det_out;

    int checks;
    int errors;

    // Reference model state: the last six bits received since reset, and how
    // many bits have arrived since then.
    logic [5:0] hist;
    int         nbits;

    moore_111010_ov dut (
        .in_seq (in_seq),
        .clk    (clk),
        .rst    (rst),
        .det_out(det_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_det();
        return (nbits >= 6) && (hist == 6'b111010);
    endfunction

    task automatic model_clear();
        hist  = 6'b0;
        nbits = 0;
    endtask

    // Drives one bit at the falling edge, lets the rising edge sample it, and
    // returns 1 time unit after that edge, when the DUT outputs can be read.
    task automatic drive_bit(input logic b);
        @(negedge clk);
        in_seq = b;
        @(posedge clk);
        hist  = {hist[4:0], b};
        nbits = nbits + 1;
        #1;
    endtask

    // Synchronous-looking reset sequence used between scenarios. Reset is
    // released 1 time unit after a rising edge, well away from any edge.
    task automatic apply_reset();
        @(negedge clk);
        rst    = 1'b1;
        in_seq = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        logic [4:0] pre;
        pre = 5'b11101;
        apply_reset();
        checks++;
        if (det_out !== 1'b0) begin
            $display("FAIL reset_initial: det_out=%b expected 0", det_out);
            errors++;
        end
        // Move the FSM into S5.
        for (int i = 0; i < 5; i++) begin
            drive_bit(pre[4-i]);
            checks++;
            if (det_out !== 1'b0) begin
                $display("FAIL reset_prefix bit %0d: det_out=%b expected 0", i, det_out);
                errors++;
            end
        end
        // Assert reset between edges. A 0 is applied while reset is held;
        // it would complete the pattern if reset were ignored.
        #2;
        rst    = 1'b1;
        in_seq = 1'b0;
        #1;
        checks++;
        if (det_out !== 1'b0) begin
            $display("FAIL reset_async_s5: det_out=%b expected 0", det_out);
            errors++;
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (det_out !== 1'b0) begin
                $display("FAIL reset_held edge %0d: det_out=%b expected 0", i, det_out);
                errors++;
            end
        end
        rst = 1'b0;
        model_clear();
        // After release, the bits "10" must not produce a detection. The
        // partial-match history must be gone.
        drive_bit(1'b1);
        drive_bit(1'b0);
        checks++;
        if (det_out !== 1'b0) begin
            $display("FAIL reset_history_cleared: det_out=%b expected 0", det_out);
            errors++;
        end
        // Reach the detect state, then assert reset mid-cycle. det_out must
        // drop at once, without waiting for a clock edge.
        apply_reset();
        begin
            logic [5:0] pat;
            pat = 6'b111010;
            for (int i = 0; i < 6; i++) drive_bit(pat[5-i]);
        end
        checks++;
        if (det_out !== 1'b1) begin
            $display("FAIL reset_pre_detect: det_out=%b expected 1", det_out);
            errors++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (det_out !== 1'b0) begin
            $display("FAIL reset_async_s6: det_out=%b expected 0", det_out);
            errors++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single();
        logic [8:0] pat;
        logic       want;
        pat = 9'b111010_000;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive_bit(pat[8-i]);
            want = (i == 5);
            checks++;
            if (det_out !== want) begin
                $display("FAIL single bit %0d: det_out=%b expected %b", i, det_out, want);
                errors++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [13:0] pat;
        logic        want;
        pat = 14'b111010_111010_00;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            drive_bit(pat[13-i]);
            want = (i == 5) || (i == 11);
            checks++;
            if (det_out !== want) begin
                $display("FAIL back_to_back bit %0d: det_out=%b expected %b", i, det_out, want);
                errors++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_overlap_run();
        logic [8:0] pat;
        logic       want;
        pat = 9'b1111010_00;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive_bit(pat[8-i]);
            want = (i == 6);
            checks++;
            if (det_out !== want) begin
                $display("FAIL overlap_run bit %0d: det_out=%b expected %b", i, det_out, want);
                errors++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_overlap_s5();
        logic [11:0] pat;
        logic        want;
        pat = 12'b111011_1010_00;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            drive_bit(pat[11-i]);
            want = (i == 9);
            checks++;
            if (det_out !== want) begin
                $display("FAIL overlap_s5 bit %0d: det_out=%b expected %b", i, det_out, want);
                errors++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_near_miss();
        logic [6:0] pats [3];
        pats[0] = 7'b111000_0;
        pats[1] = 7'b110101_0;
        pats[2] = 7'b111011_0;
        for (int p = 0; p < 3; p++) begin
            apply_reset();
            for (int i = 0; i < 7; i++) begin
                drive_bit(pats[p][6-i]);
                checks++;
                if (det_out !== 1'b0) begin
                    $display("FAIL near_miss pat %0d bit %0d: det_out=%b expected 0", p, i, det_out);
                    errors++;
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Toggle in_seq between edges in S5 (det_out=0) and in S6 (det_out=1).
    // det_out must not follow in_seq.
    task automatic test_comb();
        logic [4:0] pre;
        pre = 5'b11101;
        apply_reset();
        for (int i = 0; i < 5; i++) drive_bit(pre[4-i]);
        for (int t = 0; t < 3; t++) begin
            in_seq = ~in_seq;
            #1;
            checks++;
            if (det_out !== 1'b0) begin
                $display("FAIL comb_s5 toggle %0d: det_out=%b expected 0", t, det_out);
                errors++;
            end
        end
        drive_bit(1'b0);
        for (int t = 0; t < 3; t++) begin
            in_seq = ~in_seq;
            #1;
            checks++;
            if (det_out !== 1'b1) begin
                $display("FAIL comb_s6 toggle %0d: det_out=%b expected 1", t, det_out);
                errors++;
            end
        end
        drive_bit(1'b0);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_random();
        logic b;
        logic prev;
        int   hits;
        apply_reset();
        prev = 1'b0;
        hits = 0;
        for (int i = 0; i < 3000; i++) begin
            b = ($urandom_range(0, 99) < 65);
            drive_bit(b);
            checks++;
            if (det_out !== model_det()) begin
                $display("FAIL random bit %0d: det_out=%b expected %b", i, det_out, model_det());
                errors++;
            end
            checks++;
            if (det_out && prev) begin
                $display("FAIL random_pulse_width bit %0d: det_out=1 two cycles, expected single pulse", i);
                errors++;
            end
            if (det_out) hits++;
            prev = det_out;
            // Occasional asynchronous reset between edges.
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                checks++;
                if (det_out !== 1'b0) begin
                    $display("FAIL random_async_reset bit %0d: det_out=%b expected 0", i, det_out);
                    errors++;
                end
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_clear();
                prev = 1'b0;
            end
        end
        $display("random: %0d detections observed", hits);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        in_seq = 1'b0;
        rst    = 1'b1;
        model_clear();
        #3;
        test_reset();
        test_single();
        test_back_to_back();
        test_overlap_run();
        test_overlap_s5();
        test_near_miss();
        test_comb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/moore_111010_ov.md
Name: moore_111010_ov

Overview:
- Serial bit-stream pattern detector for the 6-bit sequence 1,1,1,0,1,0 (first bit received first).
- Implemented as a Moore FSM with overlapping detection: the tail of one match may start the next.
- Sits on a 1-bit serial input path and raises a one-cycle detect flag to downstream control logic.

Parameters:
- None. The pattern 111010 is fixed in the state encoding.

Ports:
- clk  input  1  rising-edge clock; in_seq is sampled on each rising edge
- rst  input  1  asynchronous, active-high reset; forces state S0 and det_out=0
- in_seq  input  1  serial data bit, one bit per clock
- det_out  output  1  high for exactly one clock while the FSM is in the detect state
- Port declaration order: in_seq, clk, rst, det_out. Positional instantiation depends on this order.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- rst=1 immediately forces state=S0 and det_out=0, independent of clk. This applies mid-sequence too: all partial-match history is discarded.
- While rst is held high, in_seq is ignored.
- States, 3-bit register, meaning = longest pattern prefix matched so far:
  - S0: nothing matched
  - S1: "1"
  - S2: "11"
  - S3: "111"
  - S4: "1110"
  - S5: "11101"
  - S6: "111010", the detect state
- Transitions on rising clk (in_seq=0 / in_seq=1):
  - S0: 0->S0, 1->S1
  - S1: 0->S0, 1->S2
  - S2: 0->S0, 1->S3
  - S3: 0->S4, 1->S3 (runs of four or more 1s keep the "111" prefix)
  - S4: 0->S0, 1->S5
  - S5: 0->S6, 1->S2 (suffix "11" of "111011" is retained)
  - S6: 0->S0, 1->S1 (overlap: trailing "1" restarts matching)
- Unused encoding (3'b111) goes to S0 on the next clock, with det_out=0.
- Output (Moore):
  - det_out=1 iff state==S6. It is decoded from the state register only and has no combinational path from in_seq.
  - det_out is glitch-free; registering it or decoding it from a one-hot-safe compare are both acceptable, but timing must be as below.
- Latency: if the final '0' of the pattern is sampled at rising edge k, det_out is high from just after edge k until just after edge k+1.
- Consecutive detections: in S6 only in_seq=1 (->S1) can lead to another detection. The minimum spacing between det_out pulses is 6 clocks, e.g. for 111010111010.
- det_out is never high for two consecutive cycles.

Test Plan:
- Reset: assert rst asynchronously between clock edges while in S5 -> det_out=0 and state=S0 immediately. After release, 10 (two bits) produces no detection.
- Single match: from S0, feed 1,1,1,0,1,0 on edges 1..6, then 0s -> det_out=1 only in the cycle after edge 6, 0 elsewhere.
- Back-to-back: feed 111010111010 -> det_out pulses after bit 6 and after bit 12, exactly 6 cycles apart, each one cycle wide.
- Overlap via long 1-run: feed 1111010 -> single detection after the 7th bit (S3 self-loop).
- Overlap via S5 on 1: feed 11101 1 1010, i.e. 111011 then 1010 -> detection after the 10th bit (S5 with in_seq=1 goes to S2, then S3, S4, S5, S6).
- Near misses: feed 111000, 110101, 111011 followed by 0 -> det_out stays 0 throughout. Also check det_out never responds combinationally to in_seq changes mid-cycle.
